// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ packet streams into one FIFO write port.
// A grant lasts until the packet's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic                          fifo_wr,
   input  logic                          fifo_full,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [GW-1:0]   r_grantId;
   logic [GW-1:0]   w_grantNext;
   logic [GW-1:0]   r_rrPtr;
   logic [GW-1:0]   w_rrPtrNext;
   logic [CW-1:0]   r_beatCnt;
   logic [CW-1:0]   w_beatCntNext;
   logic [NUM_REQ-1:0] w_rot;
   logic [GW:0]     w_sum;
   logic [GW-1:0]   w_pick;
   logic            w_found;
   logic            w_beat;

   // Rotating the request vector by rr_ptr turns the search into "lowest set bit".
   assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rrPtr);

   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      w_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rrPtr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NUM_REQ)) begin
               w_sum = w_sum - (GW+1)'(NUM_REQ);
            end
            w_pick = w_sum[GW-1:0];
         end
      end
   end

   always_comb begin
      fifo_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r_grantId == GW'(k)) begin
            fifo_wdata = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_grantNext   = r_grantId;
      w_rrPtrNext   = r_rrPtr;
      w_beatCntNext = r_beatCnt;
      w_beat        = 1'b0;
      req_ready     = '0;
      fifo_wr       = 1'b0;
      busy          = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grantNext   = w_pick;
               w_beatCntNext = '0;
               w_stateNext   = XFER;
            end
         end
         XFER: begin
            busy    = 1'b1;
            w_beat  = req_valid[r_grantId] & ~fifo_full;
            fifo_wr = w_beat;
            if (!fifo_full) begin
               req_ready = NUM_REQ'(1) << r_grantId;
            end
            // A burst cut ends the grant exactly like a packet end, but the
            // requester's remaining beats must win a fresh arbitration.
            if (w_beat) begin
               w_beatCntNext = r_beatCnt + 1'b1;
               if (req_last[r_grantId] || (r_beatCnt == CW'(MAX_BURST-1))) begin
                  w_stateNext = IDLE;
                  w_rrPtrNext = (r_grantId == GW'(NUM_REQ-1)) ? '0 : r_grantId + 1'b1;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_grantId <= '0;
         r_rrPtr   <= '0;
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_grantId <= w_grantNext;
         r_rrPtr   <= w_rrPtrNext;
         r_beatCnt <= w_beatCntNext;
      end
   end

   assign grant_id = r_grantId;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a packet-level reference
// model: per-requester beat queues, a round-robin pointer and a per-grant beat count.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   fifo_wdata;
   logic            fifo_wr;
   logic            fifo_full;
   logic [1:0]      grant_id;
   logic            busy;

   logic [8:0] srcQ [N][$];
   logic [7:0] sentLog [$];
   logic [7:0] wrLog [$];
   int         grantLog [$];
   int         wrCycLog [$];

   bit mBusy;
   int mGrant;
   int mPtr;
   int mCnt;
   int cyc;
   int checkCount;
   int passCount;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_wdata (fifo_wdata),
      .fifo_wr    (fifo_wr),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mBusy  = 1'b0;
      mGrant = 0;
      mPtr   = 0;
      mCnt   = 0;
      for (int i = 0; i < N; i++) srcQ[i].delete();
      sentLog.delete();
      wrLog.delete();
      grantLog.delete();
      wrCycLog.delete();
   endtask

   task automatic doReset();
      rst       = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cyc = 1;
   endtask

   task automatic loadPacket(input int r, input int len);
      for (int b = 0; b < len; b++) srcQ[r].push_back({(b == len-1), 8'($urandom)});
   endtask

   // Each requester offers the head of its own queue whenever its mask bit allows.
   task automatic drive(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i] && srcQ[i].size() > 0) begin
            req_valid[i]           = 1'b1;
            req_data[i*DW +: DW]   = srcQ[i][0][7:0];
            req_last[i]            = srcQ[i][0][8];
         end else begin
            req_valid[i]           = 1'b0;
            req_data[i*DW +: DW]   = 8'($urandom);
            req_last[i]            = 1'($urandom);
         end
      end
   endtask

   function automatic logic [15:0] expVec();
      logic [3:0] rdy;
      logic       wr;
      logic [7:0] d;
      rdy = (mBusy && !fifo_full) ? 4'(1 << mGrant) : 4'b0;
      wr  = mBusy && req_valid[mGrant] && !fifo_full;
      d   = req_data[mGrant*DW +: DW];
      return {mBusy, wr, rdy, 2'(mGrant), d};
   endfunction

   // Logs what the DUT wrote, advances the model by one clock, then steps to the next negedge.
   task automatic advance();
      logic [8:0] h;
      bit         found;
      int         idx;
      if (fifo_wr === 1'b1) begin
         wrLog.push_back(fifo_wdata);
         grantLog.push_back(int'(grant_id));
         wrCycLog.push_back(cyc);
      end
      if (!mBusy) begin
         if (req_valid != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               idx = (mPtr + k) % N;
               if (!found && req_valid[idx]) begin
                  mGrant = idx;
                  found  = 1'b1;
               end
            end
            mBusy = 1'b1;
            mCnt  = 0;
         end
      end else if (req_valid[mGrant] && !fifo_full) begin
         h = srcQ[mGrant].pop_front();
         sentLog.push_back(h[7:0]);
         mCnt++;
         if (h[8] || mCnt == MB) begin
            mBusy = 1'b0;
            mPtr  = (mGrant + 1) % N;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      req_valid = 4'hF;
      req_last  = 4'h0;
      req_data  = '0;
      fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkCount++;
      if ({busy, fifo_wr, req_ready, grant_id} !== 8'h00)
         $display("[TB] FAIL reset_hold: got busy/wr/ready/grant=%h want 00", {busy, fifo_wr, req_ready, grant_id});
      else passCount++;
   endtask

   task automatic test_single();
      int expCyc [3] = '{2, 3, 4};
      doReset();
      loadPacket(0, 3);
      for (int c = 0; c < 6; c++) begin
         drive(4'b0001); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL single_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (wrCycLog.size() != 3) $display("[TB] FAIL single_beats: got %0d beats want 3", wrCycLog.size());
      else begin
         passCount++;
         for (int i = 0; i < 3; i++) begin
            checkCount++;
            if (wrCycLog[i] != expCyc[i]) $display("[TB] FAIL single_beat_cycle: got %0d want %0d", wrCycLog[i], expCyc[i]);
            else passCount++;
         end
      end
      loadPacket(0, 1);
      loadPacket(1, 1);
      for (int c = 0; c < 4; c++) begin
         drive(4'b0011); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL rrptr_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (grantLog.size() != 5 || grantLog[3] != 1 || grantLog[4] != 0)
         $display("[TB] FAIL rrptr_after_single: got %0d writes, grant[3]=%0d want 5 writes, grant[3]=1 grant[4]=0",
                  grantLog.size(), (grantLog.size() > 3) ? grantLog[3] : -1);
      else passCount++;
   endtask

   task automatic test_round_robin();
      int expG [5] = '{0, 1, 2, 3, 0};
      int expC [5] = '{2, 4, 6, 8, 10};
      doReset();
      for (int i = 0; i < N; i++) loadPacket(i, 1);
      loadPacket(0, 1);
      for (int c = 0; c < 11; c++) begin
         drive(4'b1111); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL rr_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (grantLog.size() != 5) $display("[TB] FAIL rr_count: got %0d grants want 5", grantLog.size());
      else begin
         passCount++;
         for (int i = 0; i < 5; i++) begin
            checkCount++;
            if (grantLog[i] != expG[i] || wrCycLog[i] != expC[i])
               $display("[TB] FAIL rr_order%0d: got id %0d at cyc %0d want id %0d at cyc %0d", i, grantLog[i], wrCycLog[i], expG[i], expC[i]);
            else passCount++;
         end
      end
   endtask

   task automatic test_max_burst();
      int expG;
      doReset();
      loadPacket(2, 20);
      loadPacket(3, 1);
      for (int c = 0; c < 26; c++) begin
         drive(4'b1100); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL burst_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (grantLog.size() != 21) $display("[TB] FAIL burst_count: got %0d beats want 21", grantLog.size());
      else begin
         passCount++;
         for (int i = 0; i < 21; i++) begin
            expG = (i == 16) ? 3 : 2;
            checkCount++;
            if (grantLog[i] != expG || wrLog[i] !== sentLog[i])
               $display("[TB] FAIL burst_beat%0d: got id %0d data %h want id %0d data %h", i, grantLog[i], wrLog[i], expG, sentLog[i]);
            else passCount++;
         end
      end
   endtask

   task automatic test_full_stall();
      logic [8:0] pkt [$];
      doReset();
      loadPacket(1, 6);
      pkt = srcQ[1];
      for (int c = 0; c < 12; c++) begin
         fifo_full = (cyc >= 4 && cyc <= 6);
         drive(4'b0010); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL stall_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         if (fifo_full) begin
            checkCount++;
            if (fifo_wr !== 1'b0 || req_ready !== 4'b0)
               $display("[TB] FAIL stall_quiet: got wr=%b ready=%b want 0/0000", fifo_wr, req_ready);
            else passCount++;
         end
         advance();
      end
      fifo_full = 1'b0;
      checkCount++;
      if (wrLog.size() != 6) $display("[TB] FAIL stall_count: got %0d writes want 6", wrLog.size());
      else begin
         passCount++;
         for (int i = 0; i < 6; i++) begin
            checkCount++;
            if (wrLog[i] !== pkt[i][7:0]) $display("[TB] FAIL stall_data%0d: got %h want %h", i, wrLog[i], pkt[i][7:0]);
            else passCount++;
         end
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      loadPacket(0, 5);
      for (int c = 0; c < 2; c++) begin
         drive(4'b0001); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL rstmid_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      drive(4'b0001); #1;
      checkCount++;
      if (fifo_wr !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL rstmid_beat2: got wr=%b busy=%b want 1/1", fifo_wr, busy);
      else passCount++;
      #2 rst = 1'b0;
      #1;
      checkCount++;
      if ({busy, fifo_wr, req_ready, grant_id} !== 8'h00)
         $display("[TB] FAIL rstmid_async: got busy/wr/ready/grant=%h want 00", {busy, fifo_wr, req_ready, grant_id});
      else passCount++;
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) loadPacket(i, 1);
      for (int c = 0; c < 2; c++) begin
         drive(4'b1111); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL rstmid_after%0d: got %h want %h", c, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (grantLog.size() != 1 || grantLog[0] != 0)
         $display("[TB] FAIL rstmid_regrant: got %0d writes, first id %0d want 1 write id 0",
                  grantLog.size(), (grantLog.size() > 0) ? grantLog[0] : -1);
      else passCount++;
   endtask

   task automatic test_valid_gap();
      doReset();
      loadPacket(0, 18);
      for (int c = 0; c < 24; c++) begin
         drive((cyc == 5 || cyc == 6) ? 4'b0000 : 4'b0001); #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL gap_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         if (cyc == 5 || cyc == 6) begin
            checkCount++;
            if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wr !== 1'b0)
               $display("[TB] FAIL gap_hold: got busy=%b id=%0d wr=%b want 1/0/0", busy, grant_id, fifo_wr);
            else passCount++;
         end
         advance();
      end
      checkCount++;
      if (wrCycLog.size() != 18 || wrCycLog[15] != 19 || wrCycLog[16] != 21)
         $display("[TB] FAIL gap_timing: got %0d beats, beat16 cyc %0d want 18 beats, beat16 cyc 19, beat17 cyc 21",
                  wrCycLog.size(), (wrCycLog.size() > 15) ? wrCycLog[15] : -1);
      else passCount++;
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (srcQ[i].size() == 0 && $urandom_range(0, 3) == 0) loadPacket(i, $urandom_range(1, 20));
         fifo_full = ($urandom_range(0, 4) == 0);
         drive(4'($urandom));
         #1;
         checkCount++;
         if ({busy, fifo_wr, req_ready, grant_id, fifo_wdata} !== expVec())
            $display("[TB] FAIL rand_cyc%0d: got %h want %h", cyc, {busy, fifo_wr, req_ready, grant_id, fifo_wdata}, expVec());
         else passCount++;
         advance();
      end
      checkCount++;
      if (wrLog.size() != sentLog.size() || wrLog.size() == 0)
         $display("[TB] FAIL rand_count: got %0d writes want %0d", wrLog.size(), sentLog.size());
      else begin
         passCount++;
         for (int i = 0; i < wrLog.size(); i++) begin
            checkCount++;
            if (wrLog[i] !== sentLog[i]) $display("[TB] FAIL rand_data%0d: got %h want %h", i, wrLog[i], sentLog[i]);
            else passCount++;
         end
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      cyc        = 0;
      modelReset();
      test_reset();
      test_single();
      test_round_robin();
      test_max_burst();
      test_full_stall();
      test_reset_mid();
      test_valid_gap();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
